move_scheduler: RTL and testbench

//  Sequences the player vertical-movement datapath (y updater + y register).

---
 rtl/move_scheduler.sv | 157 +++++++++++++++
 tb/tb_move_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/move_scheduler.sv
// move_scheduler: sequences the player vertical-movement datapath.
// Generates the periodic update (frame) strobe and arbitrates the raw jump/drop
// requests into a single one-hot operation pulse. It then tracks the length of
// the move in update ticks and holds off new commands until the move ends.
// Optional feature: define MOVE_SCHED_BUFFER_EN to add a one-entry pending
// buffer. That buffer captures requests made while a move is in progress.
module move_scheduler #(
   parameter int TICK_DIV  = 833333,
   parameter int CNT_W     = 20,
   parameter int BIG_LEN   = 10,
   parameter int SMALL_LEN = 15,
   parameter int DROP_LEN  = 9
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       req_big,
   input  logic       req_small,
   input  logic       req_drop,
   output logic       update,
   output logic [2:0] operation,
   output logic       busy,
   output logic [3:0] ticks_left
);

   localparam logic [2:0] OP_NONE  = 3'b000;
   localparam logic [2:0] OP_BIG   = 3'b001;
   localparam logic [2:0] OP_SMALL = 3'b010;
   localparam logic [2:0] OP_DROP  = 3'b100;

   typedef enum logic [1:0] {IDLE, ISSUE, ACTIVE} state_t;

   state_t           state;
   logic [CNT_W-1:0] tick_cnt;
   logic [2:0]       req_sel;
   logic [2:0]       pend_op;
   logic [2:0]       start_op;

   // Move length in update ticks for a one-hot operation
   function automatic logic [3:0] op_len(input logic [2:0] op);
      logic [3:0] len;
      len = 4'd0;
      case (op)
         OP_BIG:   len = 4'(BIG_LEN);
         OP_SMALL: len = 4'(SMALL_LEN);
         OP_DROP:  len = 4'(DROP_LEN);
         default:  len = 4'd0;
      endcase
      return len;
   endfunction

   // Fixed-priority request select: drop beats big beats small
   always_comb begin
      req_sel = OP_NONE;
      if (req_drop)
         req_sel = OP_DROP;
      else if (req_big)
         req_sel = OP_BIG;
      else if (req_small)
         req_sel = OP_SMALL;
   end

   // A buffered command always wins over live requests when leaving IDLE
   assign start_op = (pend_op != OP_NONE) ? pend_op : req_sel;

   // Free-running frame divider; freezes and suppresses strobes while disabled
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tick_cnt <= '0;
         update   <= 1'b0;
      end else if (enable) begin
         if (tick_cnt == CNT_W'(TICK_DIV - 1)) begin
            tick_cnt <= '0;
            update   <= 1'b1;
         end else begin
            tick_cnt <= tick_cnt + 1'b1;
            update   <= 1'b0;
         end
      end else begin
         update <= 1'b0;
      end
   end

`ifdef MOVE_SCHED_BUFFER_EN
   // Priority rank used to decide whether a new request displaces the buffer
   function automatic logic [1:0] op_rank(input logic [2:0] op);
      logic [1:0] r;
      r = 2'd0;
      case (op)
         OP_DROP:  r = 2'd3;
         OP_BIG:   r = 2'd2;
         OP_SMALL: r = 2'd1;
         default:  r = 2'd0;
      endcase
      return r;
   endfunction

   // One-entry buffer: keeps the highest-priority request seen during a move
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_op <= OP_NONE;
      end else if (state == IDLE) begin
         // Anything buffered is issued from IDLE this very cycle
         pend_op <= OP_NONE;
      end else if (op_rank(req_sel) > op_rank(pend_op)) begin
         pend_op <= req_sel;
      end
   end
`else
   assign pend_op = OP_NONE;
`endif

   // Move sequencer with registered outputs; an update seen in ISSUE is dropped
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         operation  <= OP_NONE;
         busy       <= 1'b0;
         ticks_left <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               operation <= OP_NONE;
               busy      <= 1'b0;
               if (start_op != OP_NONE) begin
                  operation  <= start_op;
                  busy       <= 1'b1;
                  ticks_left <= op_len(start_op);
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               operation <= OP_NONE;
               state     <= ACTIVE;
            end
            ACTIVE: begin
               operation <= OP_NONE;
               if (update) begin
                  if (ticks_left <= 4'd1) begin
                     ticks_left <= 4'd0;
                     busy       <= 1'b0;
                     state      <= IDLE;
                  end else begin
                     ticks_left <= ticks_left - 4'd1;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               operation <= OP_NONE;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_move_scheduler.sv
// tb_move_scheduler: directed bench for move_scheduler with TICK_DIV=4.
// Expected values are hand-derived from the frame period and move lengths.
// The buffered-request scenario follows MOVE_SCHED_BUFFER_EN.
module tb_move_scheduler;

   logic       clk;
   logic       reset;
   logic       enable;
   logic       req_big;
   logic       req_small;
   logic       req_drop;
   logic       update;
   logic [2:0] operation;
   logic       busy;
   logic [3:0] ticks_left;

   int n_cmp = 0;
   int n_err = 0;

   move_scheduler #(
      .TICK_DIV (4),
      .CNT_W    (2),
      .BIG_LEN  (10),
      .SMALL_LEN(15),
      .DROP_LEN (9)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .req_big   (req_big),
      .req_small (req_small),
      .req_drop  (req_drop),
      .update    (update),
      .operation (operation),
      .busy      (busy),
      .ticks_left(ticks_left)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance until an update strobe is visible (bounded)
   task automatic wait_upd(input string tag);
      bit found;
      found = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if (update) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      if (!found) chk({tag, "_wait_update_timeout"}, 0, 1);
   endtask

   // Follow an ACTIVE move: each visible update must show the remaining count.
   // Optionally freeze enable for 10 clks after gap_n updates, or stop after stop_n.
   task automatic run_move(input string tag, input int len, input int gap_n, input int stop_n);
      int n;
      bit done;
      n    = 0;
      done = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (!busy) begin
            done = 1'b1;
            break;
         end
         if (update) begin
            chk({tag, "_tl"}, ticks_left, len - n);
            n++;
            if (n == gap_n) begin
               enable = 1'b0;
               repeat (10) begin
                  tick();
                  chk({tag, "_gap_update"}, update, 0);
                  chk({tag, "_gap_tl"}, ticks_left, len - n);
               end
               enable = 1'b1;
            end
            if (n == stop_n) return;
         end
         tick();
      end
      if (!done) chk({tag, "_busy_timeout"}, 0, 1);
      chk({tag, "_update_count"}, n, len);
      chk({tag, "_end_tl"}, ticks_left, 0);
      chk({tag, "_end_op"}, operation, 0);
   endtask

   initial begin
      reset     = 1'b0;
      enable    = 1'b0;
      req_big   = 1'b0;
      req_small = 1'b0;
      req_drop  = 1'b0;
      #12;
      chk("rst_update", update, 0);
      chk("rst_op", operation, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tl", ticks_left, 0);

      // Test 1: strobes on every 4th clk, idle outputs quiet
      @(posedge clk);
      #1;
      reset  = 1'b1;
      enable = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         chk("t1_update", update, (i % 4 == 0) ? 1 : 0);
      end
      chk("t1_op", operation, 0);
      chk("t1_busy", busy, 0);

      // Test 2: single-clk small jump, 15 updates
      req_small = 1'b1;
      tick();
      req_small = 1'b0;
      chk("t2_op", operation, 3'b010);
      chk("t2_tl", ticks_left, 15);
      chk("t2_busy", busy, 1);
      tick();
      chk("t2_op_pulse", operation, 0);
      run_move("t2", 15, -1, -1);
      chk("t2_busy_end", busy, 0);

      // Test 3: big+drop together, issued on an update edge (that update ignored)
      wait_upd("t3");
      repeat (3) tick();
      req_big  = 1'b1;
      req_drop = 1'b1;
      tick();
      req_big  = 1'b0;
      req_drop = 1'b0;
      chk("t3_op", operation, 3'b100);
      chk("t3_tl", ticks_left, 9);
      chk("t3_coincide_update", update, 1);
      tick();
      run_move("t3", 9, -1, -1);

      // Test 4: big jump with a 10-clk enable gap after 3 updates
      wait_upd("t4");
      req_big = 1'b1;
      tick();
      req_big = 1'b0;
      chk("t4_op", operation, 3'b001);
      chk("t4_tl", ticks_left, 10);
      tick();
      run_move("t4", 10, 3, -1);

      // Test 5: small then drop requested during a big jump
      wait_upd("t5");
      req_big = 1'b1;
      tick();
      req_big   = 1'b0;
      chk("t5_op", operation, 3'b001);
      req_small = 1'b1;
      tick();
      req_small = 1'b0;
      req_drop  = 1'b1;
      tick();
      req_drop  = 1'b0;
      run_move("t5", 10, -1, -1);
      tick();
`ifdef MOVE_SCHED_BUFFER_EN
      chk("t5_buf_op", operation, 3'b100);
      chk("t5_buf_tl", ticks_left, 9);
      chk("t5_buf_busy", busy, 1);
      tick();
      run_move("t5b", 9, -1, -1);
`else
      chk("t5_nobuf_op", operation, 0);
      chk("t5_nobuf_busy", busy, 0);
      tick();
      chk("t5_nobuf_op2", operation, 0);
      chk("t5_nobuf_busy2", busy, 0);
`endif

      // Test 6: asynchronous reset in ACTIVE with 5 ticks left
      wait_upd("t6");
      req_big = 1'b1;
      tick();
      req_big = 1'b0;
      tick();
      run_move("t6", 10, -1, 5);
      tick();
      chk("t6_tl_before", ticks_left, 5);
      chk("t6_busy_before", busy, 1);
      #2;
      reset = 1'b0;
      #1;
      chk("t6_async_update", update, 0);
      chk("t6_async_op", operation, 0);
      chk("t6_async_busy", busy, 0);
      chk("t6_async_tl", ticks_left, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk("t6_update", update, (i == 4) ? 1 : 0);
      end
      chk("t6_busy_idle", busy, 0);
      req_small = 1'b1;
      tick();
      req_small = 1'b0;
      chk("t6_reissue_op", operation, 3'b010);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
